// File: rtl/vga_display_regbank.sv
// vga_display_regbank: double-buffered 16x8 BCD register bank, back bank published to front on VSync fall.
// Optional REGBANK_BCD_CHECK_EN drops non-BCD writes and raises a sticky ErrFlag.
module vga_display_regbank (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       WrEn,
  input  logic [3:0] WrAddr,
  input  logic [7:0] WrData,
  input  logic       Commit,
  input  logic       VSync,
  input  logic [3:0] MemAddrIN,
  output logic [7:0] MemDataOut,
  output logic       Busy,
  output logic       CommitAck
`ifdef REGBANK_BCD_CHECK_EN
  ,
  output logic       ErrFlag
`endif
);
  typedef enum logic [1:0] {IDLE, PENDING, COPY, DONE} state_t;
  state_t state, state_n;
  logic [7:0] back [16];
  logic [7:0] front [16];
  logic [3:0] idx;
  logic       vs_q;
  logic       wr_req;
  logic       bcd_ok;
  assign wr_req = WrEn && state == IDLE;
`ifdef REGBANK_BCD_CHECK_EN
  assign bcd_ok = WrData[7:4] <= 4'd9 && WrData[3:0] <= 4'd9;
  always_ff @(posedge CLK)
    if (RESET) ErrFlag <= 1'b0;
    else if (wr_req && !bcd_ok) ErrFlag <= 1'b1;
`else
  assign bcd_ok = 1'b1;
`endif
  assign Busy      = state == PENDING || state == COPY;
  assign CommitAck = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = Commit ? PENDING : IDLE;
      PENDING: state_n = (vs_q && !VSync) ? COPY : PENDING;
      COPY:    state_n = idx == 4'hF ? DONE : COPY;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 16; i++) begin
        back[i]  <= 8'h00;
        front[i] <= 8'h00;
      end
      state      <= IDLE;
      idx        <= 4'd0;
      vs_q       <= 1'b0;
      MemDataOut <= 8'h00;
    end else begin
      state      <= state_n;
      vs_q       <= VSync;
      MemDataOut <= front[MemAddrIN];
      if (wr_req && bcd_ok) back[WrAddr] <= WrData;
      if (state == COPY) begin
        front[idx] <= back[idx];
        idx        <= idx + 4'd1;
      end
    end
  end
endmodule
